// File: rtl/clip_controller_if.sv
// ============================================================================
// clip_controller_if : synchronized button bus in, clip-memory strobes out
// Rev 1.0
// ============================================================================
`default_nettype none

interface clip_controller_if #(
    parameter int ADDR_W = 14
);
    logic [4:0]      sync_i;
    logic [ADDR_W:0] mem_addr_o;
    logic            mem_en_o;
    logic            mem_we_o;
    logic            recording_o;
    logic            playing_o;
    logic [1:0]      clip_valid_o;

    modport master (
        input  sync_i,
        output mem_addr_o, mem_en_o, mem_we_o, recording_o, playing_o, clip_valid_o
    );

    modport slave (
        output sync_i,
        input  mem_addr_o, mem_en_o, mem_we_o, recording_o, playing_o, clip_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/clip_controller.sv
// ============================================================================
// clip_controller : two-clip record/playback sequencer paced by a sample divider
// Rev 1.0
// ============================================================================
`default_nettype none

module clip_controller #(
    parameter int ADDR_W     = 14,
    parameter int SAMPLE_DIV = 2272
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    clip_controller_if.master   bus
);

    localparam int                DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   LEN_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECORD = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [4:0]            prev_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  clip_q, clip_d;
    logic [1:0][ADDR_W:0]  len_q, len_d;
    logic [1:0]            valid_q, valid_d;
    logic [ADDR_W:0]       mem_addr_q, mem_addr_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic                  recording_q, recording_d;
    logic                  playing_q, playing_d;

    logic                  w_clear;
    logic                  w_rec_edge;
    logic                  w_play_edge;
    logic                  w_tick;
    logic                  w_wr;
    logic                  w_rd;
    logic [ADDR_W:0]       w_len_cur;

    assign w_clear     = bus.sync_i[4];
    assign w_rec_edge  = bus.sync_i[3] & ~prev_q[3];
    assign w_play_edge = bus.sync_i[2] & ~prev_q[2];
    assign w_tick      = (div_q == DIV_LAST);
    assign w_len_cur   = len_q[clip_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            div_q       <= '0;
            addr_q      <= '0;
            clip_q      <= 1'b0;
            len_q       <= '0;
            valid_q     <= '0;
            mem_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            recording_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= bus.sync_i;
            div_q       <= div_d;
            addr_q      <= addr_d;
            clip_q      <= clip_d;
            len_q       <= len_d;
            valid_q     <= valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            recording_q <= recording_d;
            playing_q   <= playing_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        addr_d  = addr_q;
        clip_d  = clip_q;
        len_d   = len_q;
        valid_d = valid_q;
        // Soft clear is a level and outranks every edge and tick
        if (w_clear) begin
            state_d = S_IDLE;
            div_d   = '0;
            addr_d  = '0;
            len_d   = '0;
            valid_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_d = '0;
                    if (w_rec_edge) begin
                        state_d                 = S_RECORD;
                        clip_d                  = bus.sync_i[1];
                        addr_d                  = '0;
                        valid_d[bus.sync_i[1]]  = 1'b0;
                        len_d[bus.sync_i[1]]    = '0;
                    end else if (w_play_edge && valid_q[bus.sync_i[0]]) begin
                        state_d = S_PLAY;
                        clip_d  = bus.sync_i[0];
                        addr_d  = '0;
                    end
                end
                S_RECORD: begin
                    div_d = w_tick ? '0 : div_q + 1'b1;
                    if (w_rec_edge) begin
                        state_d         = S_IDLE;
                        len_d[clip_q]   = {1'b0, addr_q};
                        valid_d[clip_q] = (addr_q != '0);
                    end else if (w_tick) begin
                        if (addr_q == ADDR_LAST) begin
                            state_d         = S_IDLE;
                            len_d[clip_q]   = LEN_FULL;
                            valid_d[clip_q] = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    div_d = w_tick ? '0 : div_q + 1'b1;
                    if (w_play_edge) begin
                        state_d = S_IDLE;
                    end else if (w_tick) begin
                        if ({1'b0, addr_q} == (w_len_cur - LEN_ONE)) begin
                            state_d = S_IDLE;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d != state_q) begin
            div_d = '0;
        end
    end

    always_comb begin
        // A stop edge in the tick cycle suppresses that cycle's access
        w_wr        = ~w_clear & (state_q == S_RECORD) & w_tick & ~w_rec_edge;
        w_rd        = ~w_clear & (state_q == S_PLAY)   & w_tick & ~w_play_edge;
        mem_en_d    = w_wr | w_rd;
        mem_we_d    = w_wr;
        mem_addr_d  = (w_wr | w_rd) ? {clip_q, addr_q} : mem_addr_q;
        recording_d = (state_d == S_RECORD);
        playing_d   = (state_d == S_PLAY);
    end

    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_en_o     = mem_en_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.recording_o  = recording_q;
    assign bus.playing_o    = playing_q;
    assign bus.clip_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_clip_controller.sv
// ============================================================================
// tb_clip_controller : directed + randomized record/play sessions vs clip model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clip_controller;

    localparam int AW  = 3;
    localparam int DIV = 4;

    typedef struct {
        int          cyc;
        logic [AW:0] addr;
        logic        we;
    } strobe_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clip_controller_if #(.ADDR_W(AW)) bus();

    clip_controller #(.ADDR_W(AW), .SAMPLE_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    strobe_t    sq[$];
    int         cyc       = 0;
    int         entry_cyc = 0;
    logic       rec_d     = 1'b0;
    logic       play_d    = 1'b0;
    int         compared  = 0;
    int         mismatched = 0;
    logic [1:0] sel       = 2'b00;
    int         mlen[2];
    logic [1:0] mvalid    = 2'b00;

    // Memory-side monitor: logs every strobe and the cycle each session began
    always @(posedge clk) begin
        strobe_t s;
        #1;
        cyc = cyc + 1;
        if (bus.mem_en_o === 1'b1) begin
            s.cyc  = cyc;
            s.addr = bus.mem_addr_o;
            s.we   = bus.mem_we_o;
            sq.push_back(s);
        end
        if ((bus.recording_o === 1'b1 && !rec_d) || (bus.playing_o === 1'b1 && !play_d))
            entry_cyc = cyc;
        rec_d  = (bus.recording_o === 1'b1);
        play_d = (bus.playing_o === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic rec, input logic play);
        bus.sync_i = {1'b0, rec, play, sel};
        @(negedge clk);
        bus.sync_i = {3'b000, sel};
        @(negedge clk);
    endtask

    task automatic wait_strobes(input int n);
        for (int k = 0; k < 200 && sq.size() < n; k++) @(negedge clk);
        check("strobe_wait", sq.size(), n);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && (bus.recording_o || bus.playing_o); k++) @(negedge clk);
        check("idle_wait", {bus.recording_o, bus.playing_o}, 0);
    endtask

    task automatic check_strobes(input string tag, input logic c, input int n, input logic we);
        int prevc;
        check({tag, "_count"}, sq.size(), n);
        prevc = entry_cyc;
        for (int i = 0; i < sq.size() && i < n; i++) begin
            logic [AW:0] ea;
            ea = {c, AW'(i)};
            check({tag, "_addr"}, sq[i].addr, ea);
            check({tag, "_we"},   sq[i].we,   we);
            check({tag, "_gap"},  sq[i].cyc - prevc, DIV);
            prevc = sq[i].cyc;
        end
        sq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        bus.sync_i = 5'b10000;
        mlen[0]    = 0;
        mlen[1]    = 0;
        repeat (3) @(negedge clk);
        check("rst_addr",  bus.mem_addr_o, 0);
        check("rst_en",    bus.mem_en_o, 0);
        check("rst_we",    bus.mem_we_o, 0);
        check("rst_rec",   bus.recording_o, 0);
        check("rst_play",  bus.playing_o, 0);
        check("rst_valid", bus.clip_valid_o, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.sync_i = 5'b00000;
        repeat (100) @(negedge clk);
        check("idle_strobes", sq.size(), 0);
        check("idle_state", {bus.recording_o, bus.playing_o}, 0);

        // Record five samples into clip 1, stop manually, play them back
        sel = 2'b10;
        pulse(1'b1, 1'b0);
        check("rec1_on", bus.recording_o, 1);
        wait_strobes(5);
        pulse(1'b1, 1'b0);
        check("rec1_off", bus.recording_o, 0);
        check("rec1_valid", bus.clip_valid_o, 2'b10);
        check_strobes("rec1", 1'b1, 5, 1'b1);
        mlen[1] = 5;
        mvalid  = 2'b10;

        sel = 2'b11;
        pulse(1'b0, 1'b1);
        check("play1_on", bus.playing_o, 1);
        wait_idle();
        check_strobes("play1", 1'b1, mlen[1], 1'b0);

        // Empty clip refuses playback; simultaneous edges favour record
        sel = 2'b00;
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("empty_play", {bus.recording_o, bus.playing_o}, 0);
        check("empty_strobes", sq.size(), 0);
        pulse(1'b1, 1'b1);
        check("both_edges", {bus.recording_o, bus.playing_o}, 2'b10);
        wait_idle();
        check_strobes("rec0full", 1'b0, 8, 1'b1);
        mlen[0]   = 8;
        mvalid[0] = 1'b1;
        check("full_valid", bus.clip_valid_o, mvalid);
        pulse(1'b0, 1'b1);
        wait_idle();
        check_strobes("play0full", 1'b0, 8, 1'b0);

        // Randomized sessions with mid-operation switch changes
        for (int r = 0; r < 10; r++) begin
            logic c, pc;
            int   n, k;
            c   = 1'($urandom_range(0, 1));
            n   = $urandom_range(0, 8);
            sel = {c, 1'($urandom_range(0, 1))};
            bus.sync_i = {3'b000, sel};
            @(negedge clk);
            pulse(1'b1, 1'b0);
            check("rnd_rec_on", bus.recording_o, 1);
            sel[1]     = ~c;
            bus.sync_i = {3'b000, sel};
            if (n == 8) begin
                wait_idle();
            end else begin
                if (n > 0) wait_strobes(n);
                pulse(1'b1, 1'b0);
            end
            check("rnd_rec_off", bus.recording_o, 0);
            check_strobes("rnd_rec", c, n, 1'b1);
            mlen[c]   = n;
            mvalid[c] = (n != 0);
            check("rnd_valid", bus.clip_valid_o, mvalid);

            pc         = 1'($urandom_range(0, 1));
            sel[0]     = pc;
            bus.sync_i = {3'b000, sel};
            @(negedge clk);
            pulse(1'b0, 1'b1);
            if (mvalid[pc]) begin
                check("rnd_play_on", bus.playing_o, 1);
                k = mlen[pc];
                if (k > 1 && $urandom_range(0, 1) == 1) begin
                    k = $urandom_range(1, mlen[pc] - 1);
                    wait_strobes(k);
                    pulse(1'b0, 1'b1);
                end else begin
                    wait_idle();
                end
                check("rnd_play_off", bus.playing_o, 0);
                check_strobes("rnd_play", pc, k, 1'b0);
            end else begin
                repeat (8) @(negedge clk);
                check("rnd_noplay", bus.playing_o, 0);
                check("rnd_noplay_strobes", sq.size(), 0);
            end
        end

        // Soft clear in the middle of playback
        sel = 2'b10;
        bus.sync_i = {3'b000, sel};
        @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_idle();
        check_strobes("rec1full", 1'b1, 8, 1'b1);
        sel = 2'b11;
        pulse(1'b0, 1'b1);
        wait_strobes(3);
        bus.sync_i = {3'b100, sel};
        @(negedge clk);
        check("clr_play", bus.playing_o, 0);
        check("clr_en", bus.mem_en_o, 0);
        check("clr_valid", bus.clip_valid_o, 2'b00);
        check_strobes("clr_reads", 1'b1, 3, 1'b0);
        bus.sync_i = {3'b000, sel};
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("clr_noplay", bus.playing_o, 0);
        check("clr_noplay_strobes", sq.size(), 0);

        // Asynchronous reset while a write strobe is on the bus
        sel = 2'b00;
        pulse(1'b1, 1'b0);
        wait_strobes(1);
        check("arst_en_before", bus.mem_en_o, 1);
        rst_n = 1'b0;
        #1;
        check("arst_en", bus.mem_en_o, 0);
        check("arst_rec", bus.recording_o, 0);
        check("arst_addr", bus.mem_addr_o, 0);
        sq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("arst_quiet", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clip_controller.md
# clip_controller

Record/playback controller that consumes the 5-bit synchronized button/switch bus and turns it into clip-memory transactions. It edge-detects the record and play buttons and runs an IDLE/RECORD/PLAY state machine. It paces memory accesses with a sample-rate divider and tracks the recorded length of each of two clips. It sits between the input synchronizer and the clip sample RAM.

## Interface
- ADDR_W, 14, sample address width per clip; clip depth = 2^ADDR_W
- SAMPLE_DIV, 2272, clocks per sample tick (≥2)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- sync_q  in  5  synchronized bus: [4] soft-clear button, [3] record, [2] play, [1] write-clip select, [0] read-clip select
- mem_addr  out  ADDR_W+1  {clip, sample address}
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write qualifier, high only with mem_en in RECORD
- recording  out  1  high in RECORD
- playing  out  1  high in PLAY
- clip_valid  out  2  bit c set when clip c holds ≥1 sample

## Operation
- Edge detect: register sync_q each cycle into prev (reset 0). rec_edge = q[3]&~prev[3]; play_edge = q[2]&~prev[2].
- Soft clear: sync_q[4] high (level) forces IDLE. It also clears addr, divider, clip_valid and both lengths. It overrides every other event. The bus powers up with [4]=1, so the block stays cleared until it drops.
- Divider: counts 0..SAMPLE_DIV-1 in RECORD/PLAY only and is cleared on entering either state. tick = (div == SAMPLE_DIV-1).
- IDLE:
  - rec_edge: go to RECORD. clip = sync_q[1], addr = 0, clip_valid[clip] cleared, len[clip] cleared.
  - Otherwise play_edge with clip_valid[sync_q[0]] = 1: go to PLAY. clip = sync_q[0], addr = 0.
  - play_edge on an invalid clip: ignored.
  - rec_edge and play_edge in the same cycle: record wins.
- RECORD:
  - On tick: mem_en = mem_we = 1 at {clip, addr}, then addr+1.
  - On the tick at addr = 2^ADDR_W-1: write, then go to IDLE. len = 2^ADDR_W, valid = 1.
  - rec_edge: stop. len[clip] = addr (samples written) and clip_valid[clip] = (addr≠0); go to IDLE.
  - rec_edge on the same cycle as tick: stop wins, no write.
  - play_edge is ignored.
- PLAY:
  - On tick: mem_en = 1, mem_we = 0 at {clip, addr}, then addr+1.
  - On the tick at addr = len[clip]-1: read, then go to IDLE.
  - play_edge: go to IDLE immediately, no read that cycle.
  - rec_edge is ignored.
- len[c] is ADDR_W+1 bits wide, range 0..2^ADDR_W. addr is ADDR_W bits and never wraps.
- Switch changes mid-operation have no effect; clip is latched on entry.

## Timing
- Values after reset assertion: mem_addr = 0, mem_en = 0, mem_we = 0, recording = 0, playing = 0, clip_valid = 2'b00, state IDLE, all counters 0.
- All outputs are registered.
- An edge sampled at clock n changes state/recording/playing at clock n+1.
- The first tick occurs SAMPLE_DIV cycles after state entry.
- tick at cycle t drives mem_en/mem_we/mem_addr valid during cycle t+1, for exactly one cycle.
- Back-to-back strobes are SAMPLE_DIV cycles apart.
- mem_en is never high in IDLE.
- Async reset mid-transfer drops mem_en immediately (no glitch-free requirement on the in-flight cycle). Stored lengths are lost.

## Test plan
- Reset with sync_q = 5'b10000 held 3 cycles, then sync_q = 0 → all outputs 0, no mem_en for 100 cycles (ADDR_W=3, SAMPLE_DIV=4 for all tests).
- Pulse record with sync_q[1] = 1, allow 5 ticks, pulse record → five writes at mem_addr 8..12, 4 cycles apart, recording falls, clip_valid = 2'b10.
- Then pulse play with sync_q[0] = 1 → five reads at 8..12 with mem_we = 0, then playing falls automatically.
- Play with sync_q[0] = 0 (clip 0 empty) → no state change, no mem_en; record and play edges in the same cycle → RECORD entered.
- Record clip 0 without stop → eight writes at 0..7, auto return to IDLE, clip_valid[0] = 1; full playback reads 0..7.
- Assert sync_q[4] during PLAY after 3 reads → next cycle IDLE, mem_en = 0, clip_valid = 2'b00; a later play edge is ignored.
